c_buf: RTL and testbench

- Double-banked result buffer at the output edge of the systolic array.
- Captures one SARRAY_H-lane row of 32-bit accumulator results per write beat until a bank holds SARRAY_H rows.
- Drains the bank row by row to the tile-store path, narrowing each lane to 1/2/4 bytes and packing lanes contiguously.
- This is the mirror of the A-operand buffer, which takes packed narrow elements in and expands them to 32-bit lanes.

---
 rtl/c_buf.sv | 112 +++++++++++
 tb/tb_c_buf.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/c_buf.sv
// Double-banked result buffer: captures SARRAY_H rows of 32-bit lanes per bank,
// then drains row by row with each lane narrowed to 1/2/4 bytes and packed.
module c_buf #(
  parameter int SARRAY_H  = 4,
  parameter int C_BUF_NUM = 2,
  parameter int ID_W      = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_c_buf_valid_i,
  input  logic [ID_W-1:0]       wr_c_buf_id_i,
  input  logic [SARRAY_H*32-1:0] wr_c_buf_data_i,
  output logic                  wr_c_buf_ready_o,
  input  logic                  rd_c_buf_valid_i,
  input  logic [ID_W-1:0]       rd_c_buf_id_i,
  input  logic [2:0]            rd_c_buf_data_width_i,
  output logic                  rd_c_buf_ret_valid_o,
  output logic [SARRAY_H*32-1:0] rd_c_buf_ret_data_o,
  output logic [C_BUF_NUM-1:0]  c_buf_full_o
);
  localparam int RW = (SARRAY_H > 1) ? $clog2(SARRAY_H) : 1;
  localparam int DW = SARRAY_H * 32;

  typedef enum logic [1:0] {EMPTY, FILLING, FULL, DRAINING} bank_st_t;

  bank_st_t             st     [C_BUF_NUM];
  logic [RW-1:0]        wr_row [C_BUF_NUM];
  logic [RW-1:0]        rd_row [C_BUF_NUM];
  logic [DW-1:0]        mem    [C_BUF_NUM][SARRAY_H];

  logic [C_BUF_NUM-1:0] wr_hit, rd_hit;
  logic                 rd_acc;
  logic [DW-1:0]        rd_row_data, packed_row;
  logic [SARRAY_H*8-1:0]  p8;
  logic [SARRAY_H*16-1:0] p16;

  always_comb begin
    wr_c_buf_ready_o = 1'b0;
    rd_row_data      = '0;
    wr_hit           = '0;
    rd_hit           = '0;
    for (int b = 0; b < C_BUF_NUM; b++) begin
      if (wr_c_buf_id_i == ID_W'(b)) begin
        wr_c_buf_ready_o = (st[b] == EMPTY) || (st[b] == FILLING);
        wr_hit[b]        = wr_c_buf_valid_i && wr_c_buf_ready_o;
      end
      if (rd_c_buf_id_i == ID_W'(b)) begin
        rd_hit[b]   = rd_c_buf_valid_i && ((st[b] == FULL) || (st[b] == DRAINING));
        rd_row_data = mem[b][rd_row[b]];
      end
    end
  end

  assign rd_acc = |rd_hit;

  for (genvar i = 0; i < SARRAY_H; i++) begin : g_lane
    assign p8[i*8+:8]    = rd_row_data[i*32+:8];
    assign p16[i*16+:16] = rd_row_data[i*32+:16];
  end

  // Anything other than a clean byte/2byte one-hot drains as full 4byte lanes.
  always_comb begin
    if (rd_c_buf_data_width_i == 3'b001)      packed_row = DW'(p8);
    else if (rd_c_buf_data_width_i == 3'b010) packed_row = DW'(p16);
    else                                      packed_row = rd_row_data;
  end

  for (genvar b = 0; b < C_BUF_NUM; b++) begin : g_full
    assign c_buf_full_o[b] = (st[b] == FULL) || (st[b] == DRAINING);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int b = 0; b < C_BUF_NUM; b++) begin
        st[b]     <= EMPTY;
        wr_row[b] <= '0;
        rd_row[b] <= '0;
      end
      rd_c_buf_ret_valid_o <= 1'b0;
      rd_c_buf_ret_data_o  <= '0;
    end else begin
      for (int b = 0; b < C_BUF_NUM; b++) begin
        if (wr_hit[b]) begin
          if (wr_row[b] == RW'(SARRAY_H-1)) begin
            wr_row[b] <= '0;
            st[b]     <= FULL;
          end else begin
            wr_row[b] <= wr_row[b] + 1'b1;
            st[b]     <= FILLING;
          end
        end
        if (rd_hit[b]) begin
          if (rd_row[b] == RW'(SARRAY_H-1)) begin
            rd_row[b] <= '0;
            st[b]     <= EMPTY;
          end else begin
            rd_row[b] <= rd_row[b] + 1'b1;
            st[b]     <= DRAINING;
          end
        end
      end
      rd_c_buf_ret_valid_o <= rd_acc;
      if (rd_acc) rd_c_buf_ret_data_o <= packed_row;
    end
  end

  // Row storage carries no reset; bank state alone decides what is valid.
  always_ff @(posedge clk) begin
    for (int b = 0; b < C_BUF_NUM; b++)
      if (!rst && wr_hit[b]) mem[b][wr_row[b]] <= wr_c_buf_data_i;
  end
endmodule

// File: tb/tb_c_buf.sv
// Directed plus randomized bench for c_buf against a fill-count/queue model.
module tb_c_buf;
  localparam int H  = 4;
  localparam int NB = 2;
  localparam int DW = H * 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          wv, rv;
  logic [0:0]    wid, rid;
  logic [DW-1:0] wd;
  logic [2:0]    rw;
  logic          wready, ret_v;
  logic [DW-1:0] ret_d;
  logic [NB-1:0] full;

  int checks = 0, failures = 0;
  int fcnt[NB], dcnt[NB];
  logic [DW-1:0] mrow[NB][H];
  logic          exp_v;
  logic [DW-1:0] exp_d;

  always #5 clk = ~clk;

  c_buf #(.SARRAY_H(H), .C_BUF_NUM(NB), .ID_W(1)) dut (
    .clk(clk), .rst(rst),
    .wr_c_buf_valid_i(wv), .wr_c_buf_id_i(wid), .wr_c_buf_data_i(wd),
    .wr_c_buf_ready_o(wready),
    .rd_c_buf_valid_i(rv), .rd_c_buf_id_i(rid), .rd_c_buf_data_width_i(rw),
    .rd_c_buf_ret_valid_o(ret_v), .rd_c_buf_ret_data_o(ret_d),
    .c_buf_full_o(full)
  );

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Each lane keeps its low 8*bytes bits, lanes laid end to end from bit 0.
  function automatic logic [DW-1:0] pack(input logic [DW-1:0] row, input logic [2:0] w);
    int bytes;
    logic [DW-1:0] r;
    bytes = (w == 3'b001) ? 1 : (w == 3'b010) ? 2 : 4;
    r = '0;
    for (int i = 0; i < H; i++)
      for (int k = 0; k < bytes*8; k++) r[i*bytes*8+k] = row[i*32+k];
    return r;
  endfunction

  function automatic logic [DW-1:0] mk_row(input logic [31:0] base);
    logic [DW-1:0] r;
    for (int i = 0; i < H; i++) r[i*32+:32] = base + 32'(i);
    return r;
  endfunction

  function automatic logic [DW-1:0] rand_row();
    logic [DW-1:0] r;
    for (int i = 0; i < H; i++) r[i*32+:32] = $urandom;
    return r;
  endfunction

  function automatic logic [2:0] rand_w();
    return 3'(1 << $urandom_range(0, 2));
  endfunction

  function automatic logic [DW-1:0] exp_full();
    logic [NB-1:0] f;
    for (int b = 0; b < NB; b++) f[b] = (fcnt[b] == H);
    return DW'(f);
  endfunction

  task automatic model_reset();
    for (int b = 0; b < NB; b++) begin fcnt[b] = 0; dcnt[b] = 0; end
    exp_v = 1'b0;
    exp_d = '0;
  endtask

  task automatic cyc(input logic v_w, input int id_w, input logic [DW-1:0] d,
                     input logic v_r, input int id_r, input logic [2:0] w);
    logic wa, ra;
    wv = v_w; wid = 1'(id_w); wd = d;
    rv = v_r; rid = 1'(id_r); rw = w;
    #1;
    chk("wr_ready", DW'(wready), DW'(fcnt[id_w] < H));
    wa = v_w && (fcnt[id_w] < H);
    ra = v_r && (fcnt[id_r] == H);
    @(posedge clk); #1;
    if (wa) begin mrow[id_w][fcnt[id_w]] = d; fcnt[id_w]++; end
    exp_v = ra;
    if (ra) begin
      exp_d = pack(mrow[id_r][dcnt[id_r]], w);
      dcnt[id_r]++;
      if (dcnt[id_r] == H) begin fcnt[id_r] = 0; dcnt[id_r] = 0; end
    end
    chk("ret_valid", DW'(ret_v), DW'(exp_v));
    chk("ret_data", ret_d, exp_d);
    chk("full", DW'(full), exp_full());
  endtask

  // Requests presented alongside reset must leave no trace.
  task automatic do_reset();
    rst = 1'b1;
    wv = 1'b1; wid = 1'($urandom); wd = rand_row();
    rv = 1'b1; rid = 1'($urandom); rw = rand_w();
    @(posedge clk); #1;
    rst = 1'b0; wv = 1'b0; rv = 1'b0;
    model_reset();
    #1;
    chk("rst_full", DW'(full), '0);
    chk("rst_ret_valid", DW'(ret_v), '0);
    chk("rst_ret_data", ret_d, '0);
    chk("rst_ready", DW'(wready), DW'(1));
  endtask

  initial begin
    rst = 1'b1; wv = 1'b0; rv = 1'b0; wid = '0; rid = '0; wd = '0; rw = 3'b100;
    model_reset();
    @(posedge clk); #1;
    do_reset();

    // Fill bank 0 with the patterned rows and drain them at 4byte.
    for (int r = 0; r < H; r++) cyc(1, 0, mk_row(32'hA0B0C000 + 32'(r*16)), 0, 0, 3'b100);
    chk("b0_full_after_fill", DW'(full), DW'(2'b01));
    for (int r = 0; r < H; r++) cyc(0, 0, '0, 1, 0, 3'b100);
    chk("b0_row3_lane3", DW'(ret_d[127:96]), DW'(32'hA0B0C033));
    chk("b0_full_after_drain", DW'(full), '0);

    // Bank 1 drained at byte and 2byte widths.
    for (int r = 0; r < H; r++) cyc(1, 1, mk_row(32'h11223340), 0, 0, 3'b100);
    cyc(0, 0, '0, 1, 1, 3'b001);
    chk("b1_byte_row0", ret_d, DW'(32'h43424140));
    cyc(0, 0, '0, 1, 1, 3'b010);
    chk("b1_2byte_row1", ret_d, DW'(64'h3343334233413340));
    cyc(0, 0, '0, 1, 1, rand_w());
    cyc(0, 0, '0, 1, 1, rand_w());

    // Writes into a full bank are dropped.
    for (int r = 0; r < H; r++) cyc(1, 0, rand_row(), 0, 0, 3'b100);
    cyc(1, 0, rand_row(), 0, 0, 3'b100);
    cyc(1, 0, rand_row(), 0, 0, 3'b100);
    for (int r = 0; r < H; r++) cyc(0, 0, '0, 1, 0, rand_w());

    // Drain of an empty bank returns nothing.
    cyc(0, 0, '0, 1, 1, 3'b100);

    // Ping-pong: drain bank 0 while filling bank 1.
    for (int r = 0; r < H; r++) cyc(1, 0, rand_row(), 0, 0, 3'b100);
    for (int r = 0; r < H; r++) cyc(1, 1, rand_row(), 1, 0, rand_w());
    chk("pingpong_full", DW'(full), DW'(2'b10));
    for (int r = 0; r < H; r++) cyc(1, 1, rand_row(), 1, 1, rand_w());
    // Drain to a filling bank is ignored.
    cyc(1, 1, rand_row(), 1, 1, 3'b100);

    // Reset mid-fill, then refill and drain with a zero width code.
    cyc(1, 0, rand_row(), 0, 0, 3'b100);
    cyc(1, 0, rand_row(), 0, 0, 3'b100);
    do_reset();
    for (int r = 0; r < H; r++) cyc(1, 0, rand_row(), 0, 0, 3'b100);
    for (int r = 0; r < H; r++) cyc(0, 0, '0, 1, 0, 3'b000);

    // Random traffic, including odd width codes and occasional reset.
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 99) < 2) do_reset();
      else cyc(1'($urandom), int'($urandom_range(0, 1)), rand_row(),
               1'($urandom), int'($urandom_range(0, 1)), 3'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
